// File: rtl/mem_store_buffer_pkg.sv
// Shared definitions for the posted-write store buffer: default sizes,
// the drain FSM state encoding and a helper for the count width.
package mem_store_buffer_pkg;

  localparam int SB_DEPTH = 4;   // buffered store beats (power of two, 2..16)
  localparam int SB_AW    = 32;  // byte address width

  // Drain FSM: IDLE has nothing on the bus, BUSY presents the head entry.
  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } sb_state_t;

  // Occupancy counter must hold 0..DEPTH inclusive.
  function automatic int sb_count_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/mem_store_buffer_if.sv
// Store-buffer port bundle: M-stage write port, load hazard probe and the
// data-memory drain bus.
//
// Handshakes:
//  - Write side is valid/ready: a beat with wr_valid=1 and wr_byteen!=0 is
//    taken on the rising edge where wr_ready=1; while wr_ready=0 the producer
//    must hold the beat. wr_byteen=0 is never a transfer.
//  - Bus side is req/ack: bus_req and all bus_* payload stay stable until the
//    cycle in which bus_ack=1; that edge completes the beat. bus_ack without
//    bus_req has no effect.
interface mem_store_buffer_if #(
  parameter int AW = 32,
  parameter int CW = 3
);
  logic          wr_valid;
  logic [AW-1:0] wr_addr;
  logic [3:0]    wr_byteen;
  logic [31:0]   wr_data;
  logic          wr_ready;
  logic          ld_valid;
  logic [AW-1:0] ld_addr;
  logic          ld_hazard;
  logic          bus_req;
  logic [AW-1:0] bus_addr;
  logic [3:0]    bus_byteen;
  logic [31:0]   bus_wdata;
  logic          bus_ack;
  logic [CW-1:0] count;
  logic          empty;

  // Buffer side.
  modport slave (
    input  wr_valid, wr_addr, wr_byteen, wr_data, ld_valid, ld_addr, bus_ack,
    output wr_ready, ld_hazard, bus_req, bus_addr, bus_byteen, bus_wdata,
    output count, empty
  );

  // Pipeline / memory side.
  modport master (
    output wr_valid, wr_addr, wr_byteen, wr_data, ld_valid, ld_addr, bus_ack,
    input  wr_ready, ld_hazard, bus_req, bus_addr, bus_byteen, bus_wdata,
    input  count, empty
  );
endinterface

// File: rtl/mem_store_buffer_sb_fifo.sv
// Generic DEPTH x W register FIFO. Besides the head it exposes every slot
// plus a per-slot valid mask so the owner can compare against all pending
// entries in parallel. Storage is cleared on reset.
module sb_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push_i,
  input  logic [W-1:0]               din_i,
  input  logic                       pop_i,
  output logic [W-1:0]               dout_o,
  output logic [W-1:0]               entries_o [DEPTH],
  output logic [DEPTH-1:0]           valid_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       full_o,
  output logic                       empty_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;
  logic [PW-1:0] off [DEPTH];

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  // Full is judged on the current count, so a same-cycle pop never frees room.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Pointer and occupancy next-state; pointers wrap naturally at DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    count_d = count_q + CW'(do_push) - CW'(do_pop);
  end

  // Storage, pointers and count; everything clears on reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) mem_q[wr_ptr_q] <= din_i;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // A slot is live when its distance from the head is below the count.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      off[i]     = PW'(i) - rd_ptr_q;
      valid_o[i] = ({1'b0, off[i]} < count_q);
    end
  end

  assign dout_o    = mem_q[rd_ptr_q];
  assign entries_o = mem_q;
  assign count_o   = count_q;
endmodule

// File: rtl/mem_store_buffer.sv
// Posted-write store buffer: takes finished store beats in one cycle,
// drains them in order over a req/ack bus and flags loads that hit a
// pending word. Entries are packed {word_addr, byteen, data}.
module mem_store_buffer
  import mem_store_buffer_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH,
  parameter int AW    = SB_AW
) (
  input  logic                 clk,
  input  logic                 reset,
  mem_store_buffer_if.slave    sb,
  output sb_state_t            state_dbg
);
  localparam int CW = sb_count_w(DEPTH);
  localparam int WA = AW - 2;
  localparam int W  = WA + 4 + 32;

  sb_state_t      state_q, state_d;
  logic           push, pop, full, hit;
  logic [CW-1:0]  cnt, count_nxt;
  logic [W-1:0]   head;
  logic [W-1:0]   entries [DEPTH];
  logic [DEPTH-1:0] vld;
  logic           unused_low_addr_bits;

  // Byte offsets are irrelevant: storage and hazard work on word addresses.
  assign unused_low_addr_bits = ^{sb.wr_addr[1:0], sb.ld_addr[1:0]};

  assign push = sb.wr_valid && (sb.wr_byteen != 4'b0000) && !full;
  assign pop  = (state_q == BUSY) && sb.bus_ack;

  sb_fifo #(.DEPTH(DEPTH), .W(W)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push_i    (push),
    .din_i     ({sb.wr_addr[AW-1:2], sb.wr_byteen, sb.wr_data}),
    .pop_i     (pop),
    .dout_o    (head),
    .entries_o (entries),
    .valid_o   (vld),
    .count_o   (cnt),
    .full_o    (full),
    .empty_o   (sb.empty)
  );

  assign count_nxt = cnt + CW'(push) - CW'(pop);

  // Drain FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Drain FSM next state: leave BUSY only when the acked beat was the last.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cnt != '0) state_d = BUSY;
      BUSY:    if (sb.bus_ack && count_nxt == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Parallel word-address compare against every live entry, head included.
  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld[i] && entries[i][W-1 -: WA] == sb.ld_addr[AW-1:2]) hit = 1'b1;
    end
  end

  assign sb.ld_hazard  = sb.ld_valid && hit;
  assign sb.bus_req    = (state_q == BUSY);
  assign sb.bus_addr   = {head[W-1 -: WA], 2'b00};
  assign sb.bus_byteen = head[35:32];
  assign sb.bus_wdata  = head[31:0];
  assign sb.count      = cnt;
  assign sb.wr_ready   = !full;
  assign state_dbg     = state_q;
endmodule
